// File: rtl/clkdiv_pkg.sv
// Shared types and constants for the multi-channel clock divider.
// Combinational only: constants, channel-state type, select-width helper.
// No flow control: nothing in this package carries data.
package clkdiv_pkg;

  // Half-period giving a 2 Hz output from the 100 MHz system clock.
  localparam int CLKDIV_DIV_2HZ = 25000000;

  // Storage width of the channel-state fields; CNT_W must not exceed it.
  // Unused upper bits are held at zero so full-width compares equal
  // CNT_W-bit compares.
  localparam int CLKDIV_W_MAX = 32;

  // Architectural state of one divider channel.
  typedef struct packed {
    logic [CLKDIV_W_MAX-1:0] cnt;     // position inside the current half-period
    logic [CLKDIV_W_MAX-1:0] half;    // active half-period length, never 0
    logic [CLKDIV_W_MAX-1:0] shadow;  // last written half-period awaiting transfer
    logic                    pend;    // shadow holds a value not yet applied
    logic                    out;     // divided clock level
  } clkdiv_chan_t;

  // Ceiling log2 with a floor of 1, so a single channel still gets a select bit.
  function automatic int clkdiv_clog2_min1(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) begin
      r = r + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/clkdiv_chan.sv
// One divider channel: counter, 50% toggle, rising-edge tick, half-period update.
// Latency: clk_out/tick registered; first rise half posedges after start.
// No backpressure: en freezes the channel, writes and sync are always accepted.
// Build option CLKDIV_SHADOW_EN: writes wait in a shadow register until the
// channel's terminal count (or apply at once when disabled). Without it a
// write replaces the half-period directly and restarts the current half-period.
module clkdiv_chan
  import clkdiv_pkg::*;
#(
  parameter int CNT_W       = 25,
  parameter int DIV_DEFAULT = CLKDIV_DIV_2HZ
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             en_i,
  input  logic             wr_i,
  input  logic [CNT_W-1:0] wr_val_i,
  input  logic             sync_i,
  output logic             clk_out_o,
  output logic             tick_o
);

  localparam logic [CLKDIV_W_MAX-1:0] HALF_RST = CLKDIV_W_MAX'(DIV_DEFAULT);

  clkdiv_chan_t            st_q, st_d;
  logic                    tick_q, tick_d;
  logic [CLKDIV_W_MAX-1:0] wr_half;
  logic [CLKDIV_W_MAX-1:0] nxt_shadow;
  logic                    nxt_pend;
  logic [CNT_W-1:0]        cnt_inc;
  logic                    term;

  // Clamp a zero write to 1, form the CNT_W-wrapped increment, detect terminal count.
  always_comb begin
    wr_half = (wr_val_i == '0) ? CLKDIV_W_MAX'(1) : CLKDIV_W_MAX'(wr_val_i);
    cnt_inc = st_q.cnt[CNT_W-1:0] + CNT_W'(1);
    // Upper bits of cnt/half are always zero, so this is a CNT_W-bit compare;
    // half is never 0, so half-1 cannot underflow.
    term    = (st_q.cnt == st_q.half - CLKDIV_W_MAX'(1));
  end

  // Next channel state: sync restart, else count/toggle, plus half-period update.
  always_comb begin
    st_d   = st_q;
    tick_d = 1'b0;
`ifdef CLKDIV_SHADOW_EN
    nxt_shadow = wr_i ? wr_half : st_q.shadow;
    nxt_pend   = wr_i | st_q.pend;
`else
    // No deferred path: shadow keeps its reset value and pend stays clear.
    nxt_shadow = st_q.shadow;
    nxt_pend   = st_q.pend;
`endif
    if (sync_i) begin
      st_d.cnt    = '0;
      st_d.out    = 1'b0;
      st_d.shadow = nxt_shadow;
      st_d.pend   = 1'b0;
      if (nxt_pend) begin
        st_d.half = nxt_shadow;
      end
`ifndef CLKDIV_SHADOW_EN
      if (wr_i) begin
        st_d.half = wr_half;
      end
`endif
    end else begin
      if (en_i) begin
        if (term) begin
          st_d.cnt = '0;
          st_d.out = ~st_q.out;
          tick_d   = ~st_q.out;
        end else begin
          st_d.cnt = CLKDIV_W_MAX'(cnt_inc);
        end
      end
`ifdef CLKDIV_SHADOW_EN
      st_d.shadow = nxt_shadow;
      st_d.pend   = nxt_pend;
      // Transfer only on a half-period boundary, or at once while idle.
      if (nxt_pend && (!en_i || term)) begin
        st_d.half = nxt_shadow;
        st_d.pend = 1'b0;
      end
`else
      // Direct write restarts the current half-period at the same level.
      if (wr_i) begin
        st_d.half = wr_half;
        st_d.cnt  = '0;
        st_d.out  = st_q.out;
        tick_d    = 1'b0;
      end
`endif
    end
  end

  // State register with synchronous reset taking priority over everything.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      st_q   <= '{cnt: '0, half: HALF_RST, shadow: HALF_RST, pend: 1'b0, out: 1'b0};
      tick_q <= 1'b0;
    end else begin
      st_q   <= st_d;
      tick_q <= tick_d;
    end
  end

  assign clk_out_o = st_q.out;
  assign tick_o    = tick_q;

endmodule

// File: rtl/clk_div_multi.sv
// NCH independent runtime-programmable 50% clock dividers off the system clock.
// Latency: all outputs registered; first clk_out rise half posedges after start.
// No backpressure: writes and sync are single-cycle strobes, always accepted.
// Build option CLKDIV_SHADOW_EN selects deferred (glitch-free) half-period updates.
module clk_div_multi
  import clkdiv_pkg::*;
#(
  parameter int NCH         = 4,
  parameter int CNT_W       = 25,
  parameter int DIV_DEFAULT = CLKDIV_DIV_2HZ,
  parameter int SEL_W       = clkdiv_clog2_min1(NCH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NCH-1:0]   en,
  input  logic             div_wr,
  input  logic [SEL_W-1:0] div_sel,
  input  logic [CNT_W-1:0] div_val,
  input  logic             sync,
  output logic [NCH-1:0]   clk_out,
  output logic [NCH-1:0]   tick
);

  logic [NCH-1:0] wr_hit;

  // Decode the write strobe; a select at or beyond NCH matches no channel.
  always_comb begin
    wr_hit = '0;
    for (int i = 0; i < NCH; i++) begin
      wr_hit[i] = div_wr && (div_sel == SEL_W'(i));
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_chan
    clkdiv_chan #(
      .CNT_W       (CNT_W),
      .DIV_DEFAULT (DIV_DEFAULT)
    ) u_chan (
      .clk_i     (clk),
      .reset_i   (reset),
      .en_i      (en[g]),
      .wr_i      (wr_hit[g]),
      .wr_val_i  (div_val),
      .sync_i    (sync),
      .clk_out_o (clk_out[g]),
      .tick_o    (tick[g])
    );
  end

endmodule

// File: tb/tb_clk_div_multi.sv
// Self-checking bench for clk_div_multi (NCH=2, CNT_W=4, DIV_DEFAULT=3).
// Directed scenarios with fixed expected cycle numbers, then random stimulus
// checked every cycle against a behavioural model of the divider rules.
module tb_clk_div_multi;

  localparam int NCH   = 2;
  localparam int CNT_W = 4;
  localparam int DIVD  = 3;
  localparam int SEL_W = 1;
  localparam int WRAP  = 1 << CNT_W;

  logic             clk = 1'b0;
  logic             reset;
  logic [NCH-1:0]   en;
  logic             div_wr;
  logic [SEL_W-1:0] div_sel;
  logic [CNT_W-1:0] div_val;
  logic             sync;
  logic [NCH-1:0]   clk_out;
  logic [NCH-1:0]   tick;

  always #5 clk = ~clk;

  clk_div_multi #(
    .NCH         (NCH),
    .CNT_W       (CNT_W),
    .DIV_DEFAULT (DIVD)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .en      (en),
    .div_wr  (div_wr),
    .div_sel (div_sel),
    .div_val (div_val),
    .sync    (sync),
    .clk_out (clk_out),
    .tick    (tick)
  );

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;   // posedges since reset was released

  // Model: elapsed cycles in the half-period, level, tick, half, shadow, pending.
  int m_e[NCH];
  int m_half[NCH];
  int m_sh[NCH];
  bit m_pend[NCH];
  bit m_lvl[NCH];
  bit m_tk[NCH];

  task automatic check_eq(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Advance one enabled cycle; a half-period completes after half cycles.
  task automatic advance(input int i, input bit reached);
    if (reached) begin
      m_lvl[i] = ~m_lvl[i];
      m_tk[i]  = m_lvl[i];
      m_e[i]   = 0;
    end else begin
      m_e[i] = (m_e[i] + 1) % WRAP;
    end
  endtask

  task automatic model_step();
    for (int i = 0; i < NCH; i++) begin
      bit w;
      bit reached;
      int v;
      w = div_wr && (int'(div_sel) == i);
      v = (div_val == '0) ? 1 : int'(div_val);
      if (reset) begin
        m_e[i] = 0; m_lvl[i] = 0; m_tk[i] = 0;
        m_half[i] = DIVD; m_sh[i] = DIVD; m_pend[i] = 0;
      end else if (sync) begin
        m_e[i] = 0; m_lvl[i] = 0; m_tk[i] = 0;
`ifdef CLKDIV_SHADOW_EN
        if (w) m_half[i] = v;
        else if (m_pend[i]) m_half[i] = m_sh[i];
        if (w) m_sh[i] = v;
        m_pend[i] = 0;
`else
        if (w) m_half[i] = v;
`endif
      end else begin
        m_tk[i] = 0;
        reached = en[i] && (((m_e[i] + 1) % WRAP) == m_half[i]);
`ifdef CLKDIV_SHADOW_EN
        if (w) begin m_sh[i] = v; m_pend[i] = 1; end
        if (en[i]) advance(i, reached);
        if (m_pend[i] && (!en[i] || reached)) begin
          m_half[i] = m_sh[i];
          m_pend[i] = 0;
        end
`else
        if (w) begin
          m_half[i] = v;
          m_e[i]    = 0;
        end else if (en[i]) begin
          advance(i, reached);
        end
`endif
      end
    end
    cyc = reset ? 0 : cyc + 1;
  endtask

  // One clock: model follows the sampled inputs, outputs compared 1 ns later.
  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    for (int i = 0; i < NCH; i++) begin
      check_eq($sformatf("clk_out%0d@%0d", i, cyc), int'(clk_out[i]), int'(m_lvl[i]));
      check_eq($sformatf("tick%0d@%0d", i, cyc), int'(tick[i]), int'(m_tk[i]));
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; en = '0; div_wr = 1'b0; sync = 1'b0;
    div_sel = '0; div_val = '0;
    step();
    step();
    reset = 1'b0;
    check_eq("rst_clk_out", int'(clk_out), 0);
    check_eq("rst_tick", int'(tick), 0);
  endtask

  // Run n cycles and return the cycles of the first two toggles of channel ch.
  task automatic two_toggles(input int n, input int ch, output int ta, output int tb);
    bit prev;
    ta = -1; tb = -1;
    prev = clk_out[ch];
    for (int k = 0; k < n; k++) begin
      step();
      if (clk_out[ch] != prev) begin
        if (ta < 0) ta = cyc;
        else if (tb < 0) tb = cyc;
      end
      prev = clk_out[ch];
    end
  endtask

  initial begin
    int ta, tb, ticks, hit;
    bit prev;

    // Default half-period 3: rise at 3, fall at 6, rise at 9.
    do_reset();
    en = 2'b11;
    for (int c = 1; c <= 10; c++) begin
      step();
      check_eq("t1_level", int'(clk_out[0]), (c / 3) % 2);
      check_eq("t1_tick", int'(tick[0]), (c % 6 == 3) ? 1 : 0);
    end

    // Zero write to idle channel clamps to 1: toggle every cycle.
    do_reset();
    en = 2'b01;
    div_wr = 1'b1; div_sel = 1'b1; div_val = '0;
    step();
    div_wr = 1'b0;
    step();
    en = 2'b11;
    prev = clk_out[1];
    ticks = 0;
    for (int k = 0; k < 8; k++) begin
      step();
      check_eq("t2_toggle", int'(clk_out[1]), prev ? 0 : 1);
      prev = clk_out[1];
      ticks += int'(tick[1]);
    end
    check_eq("t2_ticks", ticks, 4);

    // Write 5 to ch0 while its count is 1.
    do_reset();
    en = 2'b01;
    step();
    div_wr = 1'b1; div_sel = 1'b0; div_val = CNT_W'(5);
    step();
    div_wr = 1'b0;
    two_toggles(20, 0, ta, tb);
`ifdef CLKDIV_SHADOW_EN
    check_eq("t3_first", ta, 3);
    check_eq("t3_second", tb, 8);
`else
    check_eq("t3_first", ta, 7);
    check_eq("t3_second", tb, 12);
`endif

    // Freeze ch0 at count 1 for 4 cycles; toggle 2 cycles after re-enable.
    do_reset();
    en = 2'b11;
    step();
    en = 2'b10;
    for (int k = 0; k < 4; k++) begin
      step();
      check_eq("t4_frozen", int'(clk_out[0]), 0);
      check_eq("t4_notick", int'(tick[0]), 0);
    end
    en = 2'b11;
    two_toggles(10, 0, ta, tb);
    check_eq("t4_resume", ta, 7);

    // Half-periods 3 and 5, then sync: common rise 15 cycles later.
    do_reset();
    en = 2'b11;
    div_wr = 1'b1; div_sel = 1'b1; div_val = CNT_W'(5);
    step();
    div_wr = 1'b0;
    for (int k = 0; k < 4; k++) step();
    sync = 1'b1;
    step();
    sync = 1'b0;
    check_eq("t5_sync_clr", int'(clk_out), 0);
    hit = -1;
    for (int k = 1; k <= 40 && hit < 0; k++) begin
      step();
      if (clk_out == 2'b11 && tick == 2'b11) hit = k;
    end
    check_eq("t5_common_rise", hit, 15);

    // Reset mid half-period with a write outstanding.
    do_reset();
    en = 2'b11;
    for (int k = 0; k < 4; k++) step();
    div_wr = 1'b1; div_sel = 1'b0; div_val = CNT_W'(7);
    step();
    div_wr = 1'b0;
    reset = 1'b1;
    step();
    check_eq("t6_rst_out", int'(clk_out), 0);
    check_eq("t6_rst_tick", int'(tick), 0);
    reset = 1'b0;
    two_toggles(10, 0, ta, tb);
    check_eq("t6_first", ta, 3);
    check_eq("t6_second", tb, 6);

    // Random traffic against the model.
    do_reset();
    en = 2'b11;
    for (int k = 0; k < 4000; k++) begin
      if ($urandom_range(0, 15) == 0) en = NCH'($urandom_range(0, 3));
      div_wr  = ($urandom_range(0, 7) == 0);
      div_sel = SEL_W'($urandom_range(0, 1));
      div_val = ($urandom_range(0, 3) == 0) ? CNT_W'($urandom_range(0, 15))
                                            : CNT_W'($urandom_range(0, 4));
      sync    = ($urandom_range(0, 99) == 0);
      reset   = ($urandom_range(0, 799) == 0);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/clk_div_multi.md
Name: clk_div_multi

Overview:
- Multi-channel, runtime-programmable successor to the fixed single-output slow-clock divider.
- Generates NCH independent divided clocks from the 100 MHz system clock. Each channel has:
  - its own half-period value;
  - an enable;
  - a one-cycle rising-edge tick.
- Feeds LED blinkers, display refresh and debouncer sampling in the top level.
- All outputs are registered and all channels are synchronous to clk.

Parameters:
- NCH, 4, number of divider channels (1..16).
- CNT_W, 25, counter/half-period width in bits.
- DIV_DEFAULT, 25000000, reset half-period in clk cycles (2 Hz output at 100 MHz).
- SEL_W, $clog2(NCH) (min 1), channel-select width.

Ports:
- clk  in  1  system clock, all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- en  in  NCH  per-channel run enable.
- div_wr  in  1  one-cycle write strobe for a half-period value.
- div_sel  in  SEL_W  channel targeted by div_wr.
- div_val  in  CNT_W  new half-period in clk cycles.
- sync  in  1  one-cycle strobe: restart all channels in phase.
- clk_out  out  NCH  divided clocks, 50 % duty.
- tick  out  NCH  one-cycle pulse coincident with each clk_out rising edge.

Behaviour:
- Reset (sampled on posedge, reset=1):
  - cnt[i]=0, clk_out=0, tick=0.
  - half[i]=DIV_DEFAULT, shadow[i]=DIV_DEFAULT, pend[i]=0.
  - Any pending write is discarded. Reset has priority over every other input.
- Running channel (en[i]=1):
  - cnt[i] counts 0..half[i]-1.
  - On the cycle cnt[i]==half[i]-1: cnt[i]<=0 and clk_out[i] toggles.
  - Output period = 2*half[i] clk cycles.
- Tick:
  - tick[i]=1 for exactly one cycle, in the same cycle clk_out[i] goes 0->1.
  - tick[i]=0 otherwise, including on the 1->0 transition.
- Latency: after reset release with en=1, the first clk_out rise is visible after half[i] posedges.
- Disabled channel (en[i]=0): cnt[i] and clk_out[i] are frozen, tick[i]=0. When re-enabled, counting resumes from the held value.
- Writes:
  - div_wr=1 loads div_val into shadow[i] where i=div_sel, and sets pend[i].
  - div_val=0 is clamped to 1 (output = clk/2).
  - div_sel>=NCH: the write is ignored.
- Write application:
  - Without the optional feature, the write is transferred as described under Optional Feature.
  - With the feature, the shadow transfers to half[i] at the next terminal count of channel i, i.e. in the same cycle as a toggle.
  - A disabled channel transfers immediately (next cycle).
  - Write and terminal count in the same cycle: the new value is used for the following half-period.
  - Back-to-back writes: the last one wins.
- sync=1:
  - All cnt<=0, all clk_out<=0, tick<=0.
  - All pending shadows are applied, pend cleared. This applies regardless of en.
  - sync has priority over terminal count and writes in the same cycle, except that a div_wr in that cycle is captured and applied too.
- Width rule:
  - The comparison cnt==half-1 is done at CNT_W bits.
  - half is never 0 (clamped), so no wrap-around underflow is possible.

Optional Feature:
- Macro: CLKDIV_SHADOW_EN.
- Defined: glitch-free deferred update. The write is held in shadow and transferred at the channel's terminal count, as in Behaviour; no half-period is ever truncated or extended.
- Undefined:
  - No shadow registers.
  - div_wr writes half[i] directly and forces cnt[i]<=0 next cycle.
  - clk_out[i] keeps its current level, so the current half-period is restarted with the new length.
  - pend logic is removed.

Decomposition:
- Package clkdiv_pkg holds:
  - the CLKDIV_DIV_2HZ=25000000 constant;
  - a clog2-with-min-1 function for SEL_W;
  - the channel-state typedef (cnt, half, shadow, pend, out).
- A natural sub-module is clkdiv_chan: one channel's counter, toggle, tick and shadow logic. The top level decodes div_sel/div_wr and generates NCH instances.

Test Plan (NCH=2, CNT_W=4, DIV_DEFAULT=3):
- Reset then en=2'b11 -> clk_out[0] rises at posedge 3, falls at 6, rises at 9; tick[0]=1 only at posedges 3 and 9.
- div_wr, sel=1, val=0 (channel idle, en[1]=0), then en[1]=1 -> clk_out[1] toggles every cycle; tick[1] pulses every 2 cycles.
- With CLKDIV_SHADOW_EN, write val=5 to ch0 when cnt=1 -> current half-period still ends at 3 cycles, subsequent half-periods are 5. Without the macro -> cnt resets, next toggle 5 cycles after the write, level unchanged.
- en[0] dropped at cnt=1 for 4 cycles -> clk_out[0] frozen, no tick; after re-enable, toggle occurs 2 cycles later.
- Ch0 half=3, ch1 half=5, then sync pulse -> both clk_out=0 and cnt=0 next cycle; both rise together on first common boundary (cycle 15).
- Reset asserted mid half-period with pending write -> next cycle all outputs 0, half back to 3, pending value never appears.
